// File: rtl/rs232in.sv
// 8N1 UART receiver: synchronised RXD, mid-bit sampling, single-entry holding
// register with valid/ack handshake, framing-error and overrun pulses.
module rs232in #(
    parameter int unsigned frequency = 50_000_000,
    parameter int unsigned bps       = 115_200
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       serial_in,
    output logic [7:0] received_data,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned PERIOD = frequency / bps;
    localparam int unsigned HALF   = PERIOD / 2;
    localparam int unsigned CNT_W  = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITHI
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [2:0]         bitn, bitn_d;
    logic [7:0]         shreg, shreg_d;
    logic [7:0]         data_d;
    logic               valid_d, ferr_d, ovr_d, busy_d;
    logic               sync1, rx;

    // Two-flop synchroniser; idle-high line so both stages reset to 1
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            rx    <= 1'b1;
        end else begin
            sync1 <= serial_in;
            rx    <= sync1;
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bitn          <= '0;
            shreg         <= '0;
            received_data <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            bitn          <= bitn_d;
            shreg         <= shreg_d;
            received_data <= data_d;
            data_valid    <= valid_d;
            framing_error <= ferr_d;
            overrun       <= ovr_d;
            busy          <= busy_d;
        end
    end

    // Next-state, bit timing and holding-register logic
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bitn_d  = bitn;
        shreg_d = shreg;
        data_d  = received_data;
        valid_d = data_valid;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (data_valid && data_ack) begin
            valid_d = 1'b0;
        end

        case (state)
            IDLE: begin
                if (!rx) begin
                    cnt_d   = CNT_W'(HALF - 1);
                    state_d = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (!rx) begin
                        cnt_d   = CNT_W'(PERIOD - 1);
                        bitn_d  = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shreg_d = {rx, shreg[7:1]};
                    cnt_d   = CNT_W'(PERIOD - 1);
                    if (bitn == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitn_d = bitn + 3'd1;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (rx) begin
                        state_d = IDLE;
                        // A same-cycle ack frees the register for the new byte
                        if (!data_valid || data_ack) begin
                            data_d  = shreg;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAITHI;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            WAITHI: begin
                if (rx) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule
